// File: rtl/cofre_controlador_pkg.sv
// Shared definitions for the safe controller: state encoding and counter sizing.
package cofre_controlador_pkg;

  typedef enum logic [1:0] {
    Fechado   = 2'd0,
    Aberto    = 2'd1,
    Bloqueado = 2'd2
  } estado_t;

  // Bits needed to hold the values 0..max_valor (at least one bit).
  function automatic int unsigned larg_contador(input int unsigned max_valor);
    return (max_valor < 1) ? 1 : $clog2(max_valor + 1);
  endfunction

endpackage

// File: rtl/cofre_controlador_comparador_tol.sv
// Combinational compare of password (a) and attempt (b): exact magnitude, sign,
// equality and "near within TOL".
module comparador_tol #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TOL   = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diferenca,
  output logic             sinal,
  output logic             igual,
  output logic             perto
);

  logic [WIDTH:0] sub;

  // One extra bit keeps the borrow so the magnitude never wraps.
  always_comb begin
    sub       = {1'b0, a} - {1'b0, b};
    sinal     = sub[WIDTH];
    diferenca = sinal ? (b - a) : sub[WIDTH-1:0];
    igual     = (a == b);
    perto     = !igual && (32'(diferenca) <= TOL);
  end

endmodule

// File: rtl/cofre_controlador.sv
// Safe controller: edge-detected submit, password compare, consecutive wrong-attempt
// counter with timed lockout, and password reprogramming while open.
module cofre_controlador
  import cofre_controlador_pkg::*;
#(
  parameter int unsigned     WIDTH       = 4,
  parameter int unsigned     TOL         = 3,
  parameter int unsigned     MAX_TENT    = 3,
  parameter int unsigned     LOCK_CYCLES = 16,
  parameter logic [WIDTH-1:0] SENHA_RESET = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [WIDTH-1:0]                 tentativa,
  input  logic                             confirma,
  input  logic                             prog,
  output logic                             led0,
  output logic                             led1,
  output logic                             led2,
  output logic [WIDTH-1:0]                 diferenca,
  output logic                             sinal,
  output logic                             bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0]    restantes
);

  localparam int unsigned RW = $clog2(MAX_TENT + 1);
  localparam int unsigned TW = larg_contador(LOCK_CYCLES);
  localparam logic [RW-1:0] RestMax  = RW'(MAX_TENT);
  localparam logic [TW-1:0] TimerMax = TW'(LOCK_CYCLES);

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] senha_q, senha_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             sinal_q, sinal_d;
  logic             led1_q, led1_d;
  logic             led2_q, led2_d;
  logic [RW-1:0]    rest_q, rest_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             conf_q;
  logic             evento;

  logic [WIDTH-1:0] cmp_dif;
  logic             cmp_sinal, cmp_igual, cmp_perto;

  comparador_tol #(
    .WIDTH (WIDTH),
    .TOL   (TOL)
  ) u_cmp (
    .a         (senha_q),
    .b         (tentativa),
    .diferenca (cmp_dif),
    .sinal     (cmp_sinal),
    .igual     (cmp_igual),
    .perto     (cmp_perto)
  );

  assign evento = confirma & ~conf_q;

  // Next-state logic: events are acted on only outside lockout.
  always_comb begin
    estado_d = estado_q;
    senha_d  = senha_q;
    dif_d    = dif_q;
    sinal_d  = sinal_q;
    led1_d   = led1_q;
    led2_d   = led2_q;
    rest_d   = rest_q;
    timer_d  = timer_q;
    case (estado_q)
      Fechado: begin
        if (evento) begin
          dif_d   = cmp_dif;
          sinal_d = cmp_sinal;
          if (cmp_igual) begin
            estado_d = Aberto;
            led1_d   = 1'b0;
            led2_d   = 1'b0;
            rest_d   = RestMax;
          end else begin
            led2_d = 1'b1;
            led1_d = cmp_perto;
            if (rest_q <= RW'(1)) begin
              rest_d   = '0;
              estado_d = Bloqueado;
              timer_d  = TimerMax;
            end else begin
              rest_d = rest_q - RW'(1);
            end
          end
        end
      end
      Aberto: begin
        if (evento) begin
          if (prog) senha_d = tentativa;
          estado_d = Fechado;
        end
      end
      Bloqueado: begin
        timer_d = timer_q - TW'(1);
        // Guarding with <= also recovers from a corrupted zero timer.
        if (timer_q <= TW'(1)) begin
          timer_d  = '0;
          estado_d = Fechado;
          rest_d   = RestMax;
          led1_d   = 1'b0;
          led2_d   = 1'b0;
        end
      end
      default: estado_d = Fechado;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= Fechado;
      senha_q  <= SENHA_RESET;
      dif_q    <= '0;
      sinal_q  <= 1'b0;
      led1_q   <= 1'b0;
      led2_q   <= 1'b0;
      rest_q   <= RestMax;
      timer_q  <= '0;
      conf_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      senha_q  <= senha_d;
      dif_q    <= dif_d;
      sinal_q  <= sinal_d;
      led1_q   <= led1_d;
      led2_q   <= led2_d;
      rest_q   <= rest_d;
      timer_q  <= timer_d;
      conf_q   <= confirma;
    end
  end

  assign led0      = (estado_q == Aberto);
  assign bloqueado = (estado_q == Bloqueado);
  assign led1      = led1_q;
  assign led2      = led2_q;
  assign diferenca = dif_q;
  assign sinal     = sinal_q;
  assign restantes = rest_q;

endmodule

// File: tb/tb_cofre_controlador.sv
// Bench for cofre_controlador: directed vector table, multi-cycle corner sequences,
// and random stimulus against a behavioural model of the safe.
module tb_cofre_controlador;

  localparam int MAXT = 3;
  localparam int LOCK = 16;
  localparam int TOLV = 3;

  logic       clock, reset, confirma, prog;
  logic [3:0] tentativa;
  logic       led0, led1, led2, sinal, bloqueado;
  logic [3:0] diferenca;
  logic [1:0] restantes;

  int checks = 0;
  int errors = 0;

  cofre_controlador dut (
    .clock     (clock),
    .reset     (reset),
    .tentativa (tentativa),
    .confirma  (confirma),
    .prog      (prog),
    .led0      (led0),
    .led1      (led1),
    .led2      (led2),
    .diferenca (diferenca),
    .sinal     (sinal),
    .bloqueado (bloqueado),
    .restantes (restantes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model of the safe.
  int m_senha, m_rest, m_timer, m_diff;
  bit m_aberto, m_bloq, m_led1, m_led2, m_sinal, m_prev;

  task automatic model_reset();
    m_senha = 0; m_rest = MAXT; m_timer = 0; m_diff = 0;
    m_aberto = 0; m_bloq = 0; m_led1 = 0; m_led2 = 0; m_sinal = 0; m_prev = 0;
  endtask

  task automatic model_clock(input int t, input bit c, input bit p);
    bit ev;
    int d;
    ev = c && !m_prev;
    m_prev = c;
    if (m_bloq) begin
      m_timer = m_timer - 1;
      if (m_timer == 0) begin
        m_bloq = 0; m_rest = MAXT; m_led1 = 0; m_led2 = 0;
      end
    end else if (m_aberto) begin
      if (ev) begin
        if (p) m_senha = t;
        m_aberto = 0;
      end
    end else if (ev) begin
      d = m_senha - t;
      m_sinal = (d < 0);
      m_diff = (d < 0) ? -d : d;
      if (m_diff == 0) begin
        m_aberto = 1; m_led1 = 0; m_led2 = 0; m_rest = MAXT;
      end else begin
        m_led2 = 1;
        m_led1 = (m_diff <= TOLV);
        m_rest = m_rest - 1;
        if (m_rest == 0) begin
          m_bloq = 1; m_timer = LOCK;
        end
      end
    end
  endtask

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " led0"}, int'(led0), int'(m_aberto));
    chk({tag, " led1"}, int'(led1), int'(m_led1));
    chk({tag, " led2"}, int'(led2), int'(m_led2));
    chk({tag, " diferenca"}, int'(diferenca), m_diff);
    chk({tag, " sinal"}, int'(sinal), int'(m_sinal));
    chk({tag, " bloqueado"}, int'(bloqueado), int'(m_bloq));
    chk({tag, " restantes"}, int'(restantes), m_rest);
  endtask

  task automatic step(input int t, input bit c, input bit p);
    tentativa = 4'(t);
    confirma  = c;
    prog      = p;
    @(posedge clock);
    model_clock(t, c, p);
    #1;
  endtask

  typedef struct {
    int t; bit c; bit p;
    bit l0; bit l1; bit l2; int dif; bit sg; bit bl; int rs;
  } vec_t;

  vec_t tab[23];

  initial begin
    tab[0]  = '{0, 1, 0,  1, 0, 0, 0, 0, 0, 3};
    tab[1]  = '{5, 0, 1,  1, 0, 0, 0, 0, 0, 3};
    tab[2]  = '{5, 1, 1,  0, 0, 0, 0, 0, 0, 3};
    tab[3]  = '{7, 0, 0,  0, 0, 0, 0, 0, 0, 3};
    tab[4]  = '{7, 1, 0,  0, 1, 1, 2, 1, 0, 2};
    tab[5]  = '{12, 0, 0, 0, 1, 1, 2, 1, 0, 2};
    tab[6]  = '{12, 1, 0, 0, 0, 1, 7, 1, 0, 1};
    tab[7]  = '{5, 0, 0,  0, 0, 1, 7, 1, 0, 1};
    tab[8]  = '{5, 1, 0,  1, 0, 0, 0, 0, 0, 3};
    tab[9]  = '{9, 0, 1,  1, 0, 0, 0, 0, 0, 3};
    tab[10] = '{9, 1, 1,  0, 0, 0, 0, 0, 0, 3};
    tab[11] = '{0, 0, 0,  0, 0, 0, 0, 0, 0, 3};
    tab[12] = '{0, 1, 0,  0, 0, 1, 9, 0, 0, 2};
    tab[13] = '{9, 0, 0,  0, 0, 1, 9, 0, 0, 2};
    tab[14] = '{9, 1, 0,  1, 0, 0, 0, 0, 0, 3};
    tab[15] = '{15, 0, 0, 1, 0, 0, 0, 0, 0, 3};
    tab[16] = '{15, 1, 0, 0, 0, 0, 0, 0, 0, 3};
    tab[17] = '{15, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    tab[18] = '{15, 1, 0, 0, 0, 1, 6, 1, 0, 2};
    tab[19] = '{12, 0, 0, 0, 0, 1, 6, 1, 0, 2};
    tab[20] = '{12, 1, 0, 0, 1, 1, 3, 1, 0, 1};
    tab[21] = '{5, 0, 0,  0, 1, 1, 3, 1, 0, 1};
    tab[22] = '{5, 1, 0,  0, 0, 1, 4, 0, 1, 0};

    // Reset state.
    reset = 1'b1; confirma = 1'b0; prog = 1'b0; tentativa = 4'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst led0", int'(led0), 0);
    chk("rst led2", int'(led2), 0);
    chk("rst bloqueado", int'(bloqueado), 0);
    chk("rst restantes", int'(restantes), 3);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 23; i++) begin
      string s;
      step(tab[i].t, tab[i].c, tab[i].p);
      s = $sformatf("vec%0d", i);
      chk({s, " led0"}, int'(led0), int'(tab[i].l0));
      chk({s, " led1"}, int'(led1), int'(tab[i].l1));
      chk({s, " led2"}, int'(led2), int'(tab[i].l2));
      chk({s, " diferenca"}, int'(diferenca), tab[i].dif);
      chk({s, " sinal"}, int'(sinal), int'(tab[i].sg));
      chk({s, " bloqueado"}, int'(bloqueado), int'(tab[i].bl));
      chk({s, " restantes"}, int'(restantes), tab[i].rs);
    end

    // Lockout: correct password pulsed mid-lock must be ignored; release after 16 cycles.
    for (int i = 1; i <= 16; i++) begin
      step(9, (i == 3 || i == 4), 0);
      check_model($sformatf("lock%0d", i));
      chk($sformatf("lock%0d bloqueado", i), int'(bloqueado), (i < 16) ? 1 : 0);
      chk($sformatf("lock%0d led0", i), int'(led0), 0);
    end
    chk("unlock restantes", int'(restantes), 3);
    chk("unlock led2", int'(led2), 0);

    // Held confirma counts as one attempt.
    step(0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0);
      check_model("hold");
    end
    chk("hold restantes", int'(restantes), 2);
    chk("hold led2", int'(led2), 1);
    chk("hold diferenca", int'(diferenca), 9);
    step(0, 0, 0);

    // Async reset between edges during lockout.
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("prelock bloqueado", int'(bloqueado), 1);
    step(0, 0, 0);
    step(0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async bloqueado", int'(bloqueado), 0);
    chk("async led2", int'(led2), 0);
    chk("async restantes", int'(restantes), 3);
    chk("async diferenca", int'(diferenca), 0);
    chk("async sinal", int'(sinal), 0);
    model_reset();
    @(posedge clock);
    #1;
    check_model("inreset");
    reset = 1'b0;

    // Password back to reset value; then the non-wrapping difference 0 - 15.
    step(0, 1, 0);
    chk("senha reset led0", int'(led0), 1);
    step(0, 0, 0);
    step(0, 1, 0);
    step(15, 0, 0);
    step(15, 1, 0);
    chk("wrap diferenca", int'(diferenca), 15);
    chk("wrap sinal", int'(sinal), 1);
    chk("wrap led1", int'(led1), 0);
    chk("wrap led2", int'(led2), 1);
    check_model("wrap");

    // Random stimulus against the model, biased toward the correct password.
    for (int n = 0; n < 600; n++) begin
      int t;
      t = ($urandom_range(0, 3) == 0) ? m_senha : int'($urandom_range(0, 15));
      step(t, ($urandom_range(0, 9) < 4), $urandom_range(0, 1) == 1);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
